// File: rtl/kmap_share_arb.sv
// Round-robin arbiter sharing one external K-map evaluator between NUM_REQ requesters.
// One transaction in flight: grant/drive operand, sample evaluator, return tagged response.
module kmap_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_abcd,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 km_a,
    output logic                 km_b,
    output logic                 km_c,
    output logic                 km_d,
    input  logic                 km_f0,
    input  logic                 km_f1,
    input  logic                 km_f2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_abcd,
    output logic [2:0]           rsp_f,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] next_ptr;
    logic            grant_valid;
    logic [3:0]      grant_abcd;
    logic [3:0]      abcd_arr [NUM_REQ];

    function automatic logic [ID_W-1:0] ring_idx(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            abcd_arr[i] = req_abcd[4*i +: 4];
        end
    end

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[ring_idx(rr_ptr, i)]) begin
                grant_valid = 1'b1;
                grant_idx   = ring_idx(rr_ptr, i);
            end
        end
    end

    assign grant_abcd = abcd_arr[grant_idx];
    assign next_ptr   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_valid) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = EVAL;
            EVAL:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand stays on the evaluator pins after the response so km_* only move on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            km_a      <= 1'b0;
            km_b      <= 1'b0;
            km_c      <= 1'b0;
            km_d      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_abcd  <= '0;
            rsp_f     <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        {km_a, km_b, km_c, km_d} <= grant_abcd;
                        rsp_abcd <= grant_abcd;
                        rsp_id   <= grant_idx;
                        rr_ptr   <= next_ptr;
                    end
                end
                EVAL: begin
                    rsp_f     <= {km_f2, km_f1, km_f0};
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_kmap_share_arb.sv
// Scoreboard bench for kmap_share_arb: directed vectors push expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_kmap_share_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_abcd;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 km_a, km_b, km_c, km_d;
    logic                 km_f0, km_f1, km_f2;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [3:0]           rsp_abcd;
    logic [2:0]           rsp_f;
    logic                 busy;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      abcd;
        logic [2:0]      f;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   assert_count = 0;
    int   fail_count   = 0;

    always #5 clk = ~clk;

    // Stand-in for the external K-map evaluator.
    assign km_f0 = km_a ^ km_b ^ km_c ^ km_d;
    assign km_f1 = (km_b & km_d) | (km_b & km_c) | (km_a & km_c) | (km_a & ~km_b & ~km_d);
    assign km_f2 = (km_b & km_c) | (~km_a & km_c) | (km_a & ~km_c);

    kmap_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_abcd(req_abcd), .req_ready(req_ready),
        .km_a(km_a), .km_b(km_b), .km_c(km_c), .km_d(km_d),
        .km_f0(km_f0), .km_f1(km_f1), .km_f2(km_f2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_abcd(rsp_abcd), .rsp_f(rsp_f),
        .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] abcd, input logic rdy);
        req_valid = valid;
        req_abcd  = abcd;
        rsp_ready = rdy;
    endtask

    task automatic pushExp(input logic [ID_W-1:0] id, input logic [3:0] abcd, input logic [2:0] f);
        exp_q.push_back({id, abcd, f});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                checkOutput("rsp_abcd", 32'(rsp_abcd), 32'(mon_e.abcd));
                checkOutput("rsp_f", 32'(rsp_f), 32'(mon_e.f));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'b0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("idle_outputs",
                32'({req_ready, busy, rsp_valid, km_a, km_b, km_c, km_d, rsp_id, rsp_abcd, rsp_f}), 32'd0);
        end

        // Single request from requester 1
        tick();
        pushExp(2'd1, 4'b1000, 3'b111);
        applyStimulus(4'b0010, 16'h0080, 1'b1);
        @(negedge clk);
        checkOutput("single_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checkOutput("single_km", 32'({km_a, km_b, km_c, km_d}), 32'b1000);
        checkOutput("single_eval_state", 32'({busy, rsp_valid, req_ready}), 32'b100000);
        tick();
        @(negedge clk);
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("single_idle", 32'({busy, rsp_valid}), 32'd0);

        // Round robin with all four requesters valid, pointer reset to 0
        tick();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        pushExp(2'd0, 4'b0000, 3'b000);
        pushExp(2'd1, 4'b0111, 3'b111);
        pushExp(2'd2, 4'b0101, 3'b010);
        pushExp(2'd3, 4'b0010, 3'b101);
        pushExp(2'd0, 4'b0000, 3'b000);
        applyStimulus(4'b1111, {4'b0010, 4'b0101, 4'b0111, 4'b0000}, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rr_grant", 32'(req_ready), 32'd1 << (k % 4));
            tick();
            if (k == 4) req_valid = 4'b0000;
            @(negedge clk);
            checkOutput("rr_eval_ready", 32'(req_ready), 32'd0);
            tick();
            @(negedge clk);
            checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            tick();
        end

        // Backpressure on a response from requester 2
        pushExp(2'd2, 4'b1010, 3'b010);
        applyStimulus(4'b0100, 16'h0A00, 1'b0);
        @(negedge clk);
        checkOutput("bp_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b1011;
        @(negedge clk);
        checkOutput("bp_eval_ready", 32'(req_ready), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_hold", 32'({rsp_valid, req_ready, rsp_id, rsp_abcd, rsp_f}),
                        32'({1'b1, 4'b0000, 2'd2, 4'b1010, 3'b010}));
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        tick();
        @(negedge clk);
        checkOutput("bp_idle", 32'({busy, rsp_valid, req_ready}), 32'd0);

        // Pointer fairness: serve 3, then 0 wins over 3
        tick();
        pushExp(2'd3, 4'b0010, 3'b101);
        pushExp(2'd0, 4'b1111, 3'b110);
        applyStimulus(4'b1000, {4'b0010, 8'h00, 4'b1111}, 1'b1);
        @(negedge clk);
        checkOutput("fair_first", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b1001;
        tick();
        tick();
        @(negedge clk);
        checkOutput("fair_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();

        // Reset during EVAL discards the operand and clears the pointer
        applyStimulus(4'b0010, {8'h00, 4'b1111, 4'h0}, 1'b1);
        @(negedge clk);
        checkOutput("mr_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #1 checkOutput("mr_async_clear", 32'({km_a, km_b, km_c, km_d, busy, rsp_valid}), 32'd0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("mr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();
        pushExp(2'd1, 4'b0111, 3'b111);
        applyStimulus(4'b1010, {4'b0010, 4'h0, 4'b0111, 4'h0}, 1'b1);
        @(negedge clk);
        checkOutput("mr_grant_lowest", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        repeat (5) tick();
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
